seg7_scan_decoder: RTL and testbench

- Reader side of the 7-segment display interface: watches a multiplexed segment bus (8-bit, same encoding our 4511-style segment driver emits) plus one-hot digit selects.
- Recovers, per digit position, the 4-bit hex value, decimal point, blank and lamp-test status.
- Sits on the board-test/monitor path so display content can be checked in hardware or fed back to logic; requires glitch-free stability before accepting a pattern.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_pattern_decode.sv | 41 ++++
 rtl/seg7_scan_decoder.sv | 149 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Segment encoding shared by the 7-segment driver and the scan decoder.
// Holds the hex code table, the blank and lamp-test patterns, the decimal-point
// bit position and the scan decoder FSM state type.
package seg7_pkg;

  localparam int unsigned DP_BIT    = 7;
  localparam logic [7:0]  SEG_BLANK = 8'h00;
  localparam logic [7:0]  SEG_LT    = 8'hFF;

  // Segment patterns (g..a) for values 0..F; the index is the hex value.
  localparam logic [6:0] SEG_CODES [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    StSeek,
    StCapture,
    StHold
  } scan_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of one captured 8-bit segment pattern.
// Ports:
//   pattern_i : segment bus value, bit7 = dp, bits6:0 = g..a
//   hex_o     : decoded value (meaningful only when valid_o)
//   valid_o   : pattern is one of the 16 hex codes (dp ignored)
//   blank_o   : pattern is all segments off
//   lt_o      : pattern is all segments on (lamp test)
//   dp_o      : decimal point bit of the pattern
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [7:0] pattern_i,
  output logic [3:0] hex_o,
  output logic       valid_o,
  output logic       blank_o,
  output logic       lt_o,
  output logic       dp_o
);

  always_comb begin
    hex_o   = 4'h0;
    valid_o = 1'b0;
    blank_o = 1'b0;
    lt_o    = 1'b0;
    dp_o    = pattern_i[DP_BIT];
    // Lamp test must win over the table: its low bits equal the code for 8.
    if (pattern_i == SEG_LT) begin
      lt_o = 1'b1;
    end else if (pattern_i == SEG_BLANK) begin
      blank_o = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (pattern_i[6:0] == SEG_CODES[i]) begin
          hex_o   = 4'(i);
          valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 7-segment bus and recovers per-digit display content.
// A pattern is captured once it has been sampled unchanged for STABLE_CYC
// consecutive edges with a one-hot digit select; each stable window is
// captured at most once.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   seg      : segment bus (bit7 = dp, bits6:0 = g..a)
//   dig_sel  : one-hot digit select
//   hex      : decoded value per digit, digit i at [4i+3:4i]
//   dp, valid, blank, lt : per-digit status of the last capture
//   upd, upd_idx : capture strobe and captured digit index
//   sel_err  : strobe, dig_sel sampled with two or more bits set
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        seg,
  input  logic [NDIG-1:0]   dig_sel,
  output logic [4*NDIG-1:0] hex,
  output logic [NDIG-1:0]   dp,
  output logic [NDIG-1:0]   valid,
  output logic [NDIG-1:0]   blank,
  output logic [NDIG-1:0]   lt,
  output logic              upd,
  output logic [2:0]        upd_idx,
  output logic              sel_err
);

  localparam logic [7:0] StableCnt = 8'(STABLE_CYC);

  scan_state_e       state_q, state_d;
  logic [7:0]        s_seg_q;
  logic [NDIG-1:0]   s_sel_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [4*NDIG-1:0] hex_q;
  logic [NDIG-1:0]   dp_q, valid_q, blank_q, lt_q;
  logic              upd_q, sel_err_q;
  logic [2:0]        upd_idx_q;

  logic       changed, sel_onehot, sel_multi, capture;
  logic [2:0] cap_idx;
  logic [3:0] dec_hex;
  logic       dec_valid, dec_blank, dec_lt, dec_dp;

  assign changed    = (seg != s_seg_q) || (dig_sel != s_sel_q);
  assign sel_onehot = $onehot(dig_sel);
  assign sel_multi  = !$onehot0(dig_sel);

  always_comb begin
    if (!sel_onehot) begin
      cnt_d = 8'd0;
    end else if (changed) begin
      cnt_d = 8'd1;
    end else if (cnt_q >= StableCnt) begin
      cnt_d = StableCnt;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      StSeek: begin
        if (sel_onehot && (cnt_d == StableCnt)) state_d = StCapture;
      end
      StCapture: begin
        // A change arriving on the capture edge voids the window.
        if (changed) begin
          state_d = StSeek;
        end else begin
          capture = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (changed) state_d = StSeek;
      end
      default: state_d = StSeek;
    endcase
  end

  always_comb begin
    cap_idx = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (s_sel_q[i]) cap_idx = 3'(i);
    end
  end

  seg7_pattern_decode u_decode (
    .pattern_i (s_seg_q),
    .hex_o     (dec_hex),
    .valid_o   (dec_valid),
    .blank_o   (dec_blank),
    .lt_o      (dec_lt),
    .dp_o      (dec_dp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StSeek;
      s_seg_q   <= 8'd0;
      s_sel_q   <= '0;
      cnt_q     <= 8'd0;
      hex_q     <= '0;
      dp_q      <= '0;
      valid_q   <= '0;
      blank_q   <= '0;
      lt_q      <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= 3'd0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_seg_q   <= seg;
      s_sel_q   <= dig_sel;
      cnt_q     <= cnt_d;
      upd_q     <= capture;
      sel_err_q <= sel_multi;
      if (capture) begin
        upd_idx_q <= cap_idx;
        for (int i = 0; i < NDIG; i++) begin
          if (s_sel_q[i]) begin
            dp_q[i]    <= dec_dp;
            valid_q[i] <= dec_valid;
            blank_q[i] <= dec_blank;
            lt_q[i]    <= dec_lt;
            if (dec_valid) hex_q[4*i +: 4] <= dec_hex;
          end
        end
      end
    end
  end

  assign hex     = hex_q;
  assign dp      = dp_q;
  assign valid   = valid_q;
  assign blank   = blank_q;
  assign lt      = lt_q;
  assign upd     = upd_q;
  assign upd_idx = upd_idx_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg;
  logic [3:0]  dig_sel;
  logic [15:0] hex;
  logic [3:0]  dp, valid, blank, lt;
  logic        upd;
  logic [2:0]  upd_idx;
  logic        sel_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .NDIG       (4),
    .STABLE_CYC (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .seg     (seg),
    .dig_sel (dig_sel),
    .hex     (hex),
    .dp      (dp),
    .valid   (valid),
    .blank   (blank),
    .lt      (lt),
    .upd     (upd),
    .upd_idx (upd_idx),
    .sel_err (sel_err)
  );

  // Inputs are driven and outputs observed 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; seg = 8'h00; dig_sel = 4'b0000;
    tick; tick;
    checks++;
    if ({hex, dp, valid, blank, lt} !== 32'h0) begin
      errors++;
      $display("FAIL reset_fields got %h want 0", {hex, dp, valid, blank, lt});
    end
    checks++;
    if ({upd, upd_idx, sel_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 0", {upd, upd_idx, sel_err});
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    int n = 0;
    seg = 8'h5B; dig_sel = 4'b0010;
    for (int k = 1; k <= 10; k++) begin
      tick;
      checks++;
      if (upd !== 1'(k == 5)) begin
        errors++;
        $display("FAIL single_upd tick %0d got %b want %b", k, upd, (k == 5));
      end
      if (upd === 1'b1) n++;
      if (k == 5) begin
        checks++;
        if (upd_idx !== 3'd1) begin
          errors++;
          $display("FAIL single_idx got %0d want 1", upd_idx);
        end
      end
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL single_count got %0d want 1", n);
    end
    checks++;
    if ({hex, valid, dp, blank, lt} !== {16'h0020, 4'b0010, 12'h0}) begin
      errors++;
      $display("FAIL single_fields got %h %b want 0020 0010", hex, valid);
    end
  endtask

  task automatic test_scan;
    logic [7:0] pats [4];
    int n = 0;
    pats = '{8'h06, 8'h4F, 8'h66, 8'hED};
    for (int d = 0; d < 4; d++) begin
      seg = pats[d]; dig_sel = 4'(1 << d);
      for (int k = 1; k <= 6; k++) begin
        tick;
        if (upd === 1'b1) begin
          n++;
          checks++;
          if (k != 5 || upd_idx !== 3'(d)) begin
            errors++;
            $display("FAIL scan_upd digit %0d tick %0d idx %0d want tick 5 idx %0d",
                     d, k, upd_idx, d);
          end
        end
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL scan_count got %0d want 4", n);
    end
    checks++;
    if (hex !== 16'h5431) begin
      errors++;
      $display("FAIL scan_hex got %h want 5431", hex);
    end
    checks++;
    if ({dp, valid, blank, lt} !== {4'b1000, 4'hF, 8'h00}) begin
      errors++;
      $display("FAIL scan_flags got %b %b %b %b want 1000 1111 0000 0000", dp, valid, blank, lt);
    end
  endtask

  task automatic test_glitch;
    int n = 0;
    rst = 1'b1; tick; rst = 1'b0;
    dig_sel = 4'b0001;
    for (int t = 0; t < 4; t++) begin
      seg = t[0] ? 8'h06 : 8'h3F;
      for (int k = 0; k < 3; k++) begin
        tick;
        if (upd === 1'b1) n++;
      end
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL glitch_upd got %0d pulses want 0", n);
    end
    checks++;
    if ({hex[3:0], valid[0], dp[0], blank[0], lt[0]} !== 8'h00) begin
      errors++;
      $display("FAIL glitch_digit0 got %h %b want 0 0", hex[3:0], valid[0]);
    end
  endtask

  task automatic test_sel_err;
    int n_err = 0;
    int n_upd = 0;
    dig_sel = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (sel_err === 1'b1) n_err++;
      if (upd === 1'b1) n_upd++;
    end
    dig_sel = 4'b0000;
    tick;
    checks++;
    if (sel_err !== 1'b0) begin
      errors++;
      $display("FAIL sel_err_drop got %b want 0", sel_err);
    end
    checks++;
    if (n_err != 5) begin
      errors++;
      $display("FAIL sel_err_count got %0d want 5", n_err);
    end
    for (int k = 0; k < 6; k++) begin
      tick;
      if (sel_err === 1'b1) n_err++;
      if (upd === 1'b1) n_upd++;
    end
    checks++;
    if (n_err != 5 || n_upd != 0) begin
      errors++;
      $display("FAIL sel_zero got sel_err %0d upd %0d want 5 0", n_err, n_upd);
    end
  endtask

  task automatic test_lt_blank;
    dig_sel = 4'b0100;
    seg = 8'h79;
    repeat (6) tick;
    checks++;
    if (hex[11:8] !== 4'hE || valid[2] !== 1'b1) begin
      errors++;
      $display("FAIL ltb_prime got %h %b want e 1", hex[11:8], valid[2]);
    end
    seg = 8'hFF;
    repeat (6) tick;
    checks++;
    if ({lt[2], valid[2], dp[2], blank[2], hex[11:8]} !== 8'b1010_1110) begin
      errors++;
      $display("FAIL ltb_lamp got lt %b v %b dp %b bl %b hex %h want 1 0 1 0 e",
               lt[2], valid[2], dp[2], blank[2], hex[11:8]);
    end
    seg = 8'h00;
    repeat (6) tick;
    checks++;
    if ({lt[2], valid[2], dp[2], blank[2], hex[11:8]} !== 8'b0001_1110) begin
      errors++;
      $display("FAIL ltb_blank got lt %b v %b dp %b bl %b hex %h want 0 0 0 1 e",
               lt[2], valid[2], dp[2], blank[2], hex[11:8]);
    end
    seg = 8'hC9; // not a hex code, dp set
    repeat (6) tick;
    checks++;
    if ({lt[2], valid[2], dp[2], blank[2], hex[11:8]} !== 8'b0010_1110) begin
      errors++;
      $display("FAIL ltb_illegal got lt %b v %b dp %b bl %b hex %h want 0 0 1 0 e",
               lt[2], valid[2], dp[2], blank[2], hex[11:8]);
    end
    checks++;
    if ({hex[15:12], hex[7:0], valid[3], valid[1:0]} !== 15'h0) begin
      errors++;
      $display("FAIL ltb_others got hex %h valid %b want other digits 0", hex, valid);
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    dig_sel = 4'b0001;
    seg = 8'h06;
    repeat (4) tick;
    seg = 8'h4F; // sampled on what would be the capture edge
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (upd === 1'b1) begin
        n++;
        checks++;
        if (k != 5) begin
          errors++;
          $display("FAIL b2b_timing got upd at tick %0d want 5", k);
        end
      end
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL b2b_count got %0d want 1", n);
    end
    checks++;
    if (hex[3:0] !== 4'h3 || valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hex got %h %b want 3 1", hex[3:0], valid[0]);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    dig_sel = 4'b1000;
    seg = 8'h7F;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    checks++;
    if ({hex, dp, valid, blank, lt, upd, upd_idx, sel_err} !== 37'h0) begin
      errors++;
      $display("FAIL rmid_clear got hex %h valid %b upd %b want 0", hex, valid, upd);
    end
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick;
      if (upd === 1'b1) begin
        n++;
        checks++;
        if (k != 5 || upd_idx !== 3'd3) begin
          errors++;
          $display("FAIL rmid_upd got tick %0d idx %0d want 5 3", k, upd_idx);
        end
      end
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL rmid_count got %0d want 1", n);
    end
    checks++;
    if (hex !== 16'h8000 || valid !== 4'b1000) begin
      errors++;
      $display("FAIL rmid_hex got %h %b want 8000 1000", hex, valid);
    end
  endtask

  initial begin
    rst = 1'b1; seg = 8'h00; dig_sel = 4'b0000;
    test_reset;
    test_single;
    test_scan;
    test_glitch;
    test_sel_err;
    test_lt_blank;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
